// File: rtl/dtc_cali_err_gen.sv
// dtc_cali_err_gen: front end for the piecewise DTC calibrator.
// Runs the fractional phase accumulator (X_NOW, CARRY) and saturates the
// calibrator correction into DTC_CODE. It also turns BBPD decisions into a
// signed error (ERR_OUT) that is paired with a LAT-delayed phase (X_ALN).
// A start-up FSM (IDLE/FILL/SETTLE/TRACK) gates the CALI_EN update strobe.
// Ports: CLK, NRST (async, active-low), EN, FCW_FRAC, Y_CAL (signed),
//        PHE_SIGN, PHE_VLD -> X_NOW, CARRY, DTC_CODE, X_ALN, ERR_OUT,
//        CALI_EN, STATE.
// Option: define DTC_DITHER_EN to add a 15-bit LFSR carry-in dither.
module dtc_cali_err_gen #(
    parameter int WF         = 16,
    parameter int WD         = 10,
    parameter int WE         = 8,
    parameter int LAT        = 3,
    parameter int SETTLE_CYC = 64,
    parameter int ERR_STEP   = 16
) (
    input  logic          CLK,
    input  logic          NRST,
    input  logic          EN,
    input  logic [WF-1:0] FCW_FRAC,
    input  logic [WD+1:0] Y_CAL,
    input  logic          PHE_SIGN,
    input  logic          PHE_VLD,
    output logic [WF-1:0] X_NOW,
    output logic          CARRY,
    output logic [WD-1:0] DTC_CODE,
    output logic [WF-1:0] X_ALN,
    output logic [WE-1:0] ERR_OUT,
    output logic          CALI_EN,
    output logic [1:0]    STATE
);

    localparam int CW = $clog2(SETTLE_CYC + LAT + 1);
    localparam logic [WE-1:0] STEP_P = WE'(ERR_STEP);
    localparam logic [WE-1:0] STEP_N = ~STEP_P + WE'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        SETTLE = 2'd2,
        TRACK  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WF-1:0] acc_q;
    logic          carry_q;
    logic [WD-1:0] dtc_q, dtc_d;
    logic [WF-1:0] xaln_q;
    logic [WE-1:0] err_q;
    logic          cali_q;
    logic [LAT-1:0]          dv_q;
    logic [LAT-1:0][WF-1:0]  dx_q;
    logic          cin;
    logic [WF:0]   sum_d;
    logic          tail_vld;
    logic [WF-1:0] tail_x;
    logic          trk_smp;

`ifdef DTC_DITHER_EN
    // x^15 + x^14 + 1; LSB is the +1 LSB dither carry-in.
    logic [14:0] lfsr_q;

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            lfsr_q <= 15'h0001;
        end else if (EN) begin
            lfsr_q <= {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
        end
    end

    assign cin = lfsr_q[0];
`else
    assign cin = 1'b0;
`endif

    assign sum_d = {1'b0, acc_q} + {1'b0, FCW_FRAC} + {{WF{1'b0}}, cin};

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
        end else if (EN) begin
            acc_q   <= sum_d[WF-1:0];
            carry_q <= sum_d[WF];
        end else begin
            carry_q <= 1'b0;
        end
    end

    // Correction is signed: negative clamps to 0, and bit WD set means
    // the value is above the DTC range.
    always_comb begin
        dtc_d = Y_CAL[WD-1:0];
        if (Y_CAL[WD+1]) begin
            dtc_d = '0;
        end else if (Y_CAL[WD]) begin
            dtc_d = '1;
        end
    end

    // Delay line: EN low clears every valid bit on the same edge.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            dv_q <= '0;
            dx_q <= '0;
        end else begin
            dv_q[0] <= EN;
            dx_q[0] <= acc_q;
            for (int i = 1; i < LAT; i++) begin
                dv_q[i] <= EN & dv_q[i-1];
                dx_q[i] <= dx_q[i-1];
            end
        end
    end

    assign tail_vld = dv_q[LAT-1];
    assign tail_x   = dx_q[LAT-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (EN) begin
                    state_d = FILL;
                    cnt_d   = '0;
                end
            end
            FILL: begin
                cnt_d = cnt_q + CW'(1);
                if (tail_vld) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                if (tail_vld && PHE_VLD) begin
                    if (cnt_q == CW'(SETTLE_CYC - 1)) begin
                        state_d = TRACK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            TRACK: begin
                state_d = TRACK;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!EN) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // A sample taken while EN is low is discarded with the pipeline.
    assign trk_smp = (state_q == TRACK) & EN & tail_vld & PHE_VLD;

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dtc_q   <= '0;
            err_q   <= '0;
            cali_q  <= 1'b0;
            xaln_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dtc_q   <= dtc_d;
            cali_q  <= trk_smp;
            err_q   <= trk_smp ? (PHE_SIGN ? STEP_P : STEP_N) : '0;
            if (trk_smp) begin
                xaln_q <= tail_x;
            end
        end
    end

    assign X_NOW    = acc_q;
    assign CARRY    = carry_q;
    assign DTC_CODE = dtc_q;
    assign X_ALN    = xaln_q;
    assign ERR_OUT  = err_q;
    assign CALI_EN  = cali_q;
    assign STATE    = state_q;

endmodule

// File: tb/tb_dtc_cali_err_gen.sv
// tb_dtc_cali_err_gen: directed bench for dtc_cali_err_gen (default build).
// Expected phases come from a bench-side accumulator model.
module tb_dtc_cali_err_gen;

    logic        CLK = 1'b0;
    logic        NRST;
    logic        EN;
    logic [15:0] FCW_FRAC;
    logic [11:0] Y_CAL;
    logic        PHE_SIGN;
    logic        PHE_VLD;
    logic [15:0] X_NOW;
    logic        CARRY;
    logic [9:0]  DTC_CODE;
    logic [15:0] X_ALN;
    logic [7:0]  ERR_OUT;
    logic        CALI_EN;
    logic [1:0]  STATE;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [15:0] xm;
    logic [15:0] xhist [0:1023];

    dtc_cali_err_gen dut (
        .CLK(CLK), .NRST(NRST), .EN(EN), .FCW_FRAC(FCW_FRAC),
        .Y_CAL(Y_CAL), .PHE_SIGN(PHE_SIGN), .PHE_VLD(PHE_VLD),
        .X_NOW(X_NOW), .CARRY(CARRY), .DTC_CODE(DTC_CODE),
        .X_ALN(X_ALN), .ERR_OUT(ERR_OUT), .CALI_EN(CALI_EN),
        .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: update the phase model with the inputs seen at the
    // edge, then sample on the falling edge.
    task automatic step();
        @(posedge CLK);
        if (EN) xm = xm + FCW_FRAC;
        @(negedge CLK);
        cyc++;
        xhist[cyc] = xm;
    endtask

    initial begin
        NRST = 1'b0; EN = 1'b0; FCW_FRAC = 16'h4000;
        Y_CAL = 12'd0; PHE_SIGN = 1'b0; PHE_VLD = 1'b0;
        xm = 16'h0;
        xhist[0] = 16'h0;
        #12;
        chk("rst_x", {16'h0, X_NOW}, 32'h0);
        chk("rst_carry", {31'h0, CARRY}, 32'h0);
        chk("rst_state", {30'h0, STATE}, 32'h0);
        chk("rst_cali", {31'h0, CALI_EN}, 32'h0);
        chk("rst_err", {24'h0, ERR_OUT}, 32'h0);
        chk("rst_dtc", {22'h0, DTC_CODE}, 32'h0);
        chk("rst_xaln", {16'h0, X_ALN}, 32'h0);
        @(negedge CLK);
        NRST = 1'b1;

        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_x", {16'h0, X_NOW}, 32'h0);
            chk("idle_carry", {31'h0, CARRY}, 32'h0);
            chk("idle_state", {30'h0, STATE}, 32'h0);
            chk("idle_cali", {31'h0, CALI_EN}, 32'h0);
        end

        Y_CAL = 12'hFFB;
        step();
        chk("dtc_neg", {22'h0, DTC_CODE}, 32'd0);
        Y_CAL = 12'd1500;
        step();
        chk("dtc_hi", {22'h0, DTC_CODE}, 32'd1023);
        Y_CAL = 12'd300;
        chk("dtc_lat", {22'h0, DTC_CODE}, 32'd1023);
        step();
        chk("dtc_mid", {22'h0, DTC_CODE}, 32'd300);
        Y_CAL = 12'd1024;
        step();
        chk("dtc_1024", {22'h0, DTC_CODE}, 32'd1023);
        Y_CAL = 12'd1023;
        step();
        chk("dtc_1023", {22'h0, DTC_CODE}, 32'd1023);
        Y_CAL = 12'd0;
        step();
        chk("dtc_zero", {22'h0, DTC_CODE}, 32'd0);

        // Start-up with wrap check, PHE_VLD held high.
        EN = 1'b1; PHE_VLD = 1'b1;
        step();
        chk("w1_x", {16'h0, X_NOW}, 32'h4000);
        chk("w1_c", {31'h0, CARRY}, 32'h0);
        chk("fill1", {30'h0, STATE}, 32'd1);
        step();
        chk("w2_x", {16'h0, X_NOW}, 32'h8000);
        chk("w2_c", {31'h0, CARRY}, 32'h0);
        chk("fill2", {30'h0, STATE}, 32'd1);
        step();
        chk("w3_x", {16'h0, X_NOW}, 32'hC000);
        chk("w3_c", {31'h0, CARRY}, 32'h0);
        chk("fill3", {30'h0, STATE}, 32'd1);
        step();
        chk("w4_x", {16'h0, X_NOW}, 32'h0000);
        chk("w4_c", {31'h0, CARRY}, 32'h1);
        chk("settle_in", {30'h0, STATE}, 32'd2);
        step();
        chk("w5_x", {16'h0, X_NOW}, 32'h4000);
        chk("w5_c", {31'h0, CARRY}, 32'h0);
        FCW_FRAC = 16'h0123;

        // 64 aligned samples in SETTLE (the two above included).
        for (int i = 0; i < 62; i++) begin
            step();
            chk("settle_st", {30'h0, STATE}, 32'd2);
            chk("settle_cali", {31'h0, CALI_EN}, 32'h0);
            chk("settle_x", {16'h0, X_NOW}, {16'h0, xm});
        end
        step();
        chk("track_in", {30'h0, STATE}, 32'd3);
        chk("track_cali0", {31'h0, CALI_EN}, 32'h0);

        PHE_SIGN = 1'b1;
        step();
        chk("t1_cali", {31'h0, CALI_EN}, 32'h1);
        chk("t1_err", {24'h0, ERR_OUT}, 32'h10);
        chk("t1_xaln", {16'h0, X_ALN}, {16'h0, xhist[cyc-4]});
        PHE_SIGN = 1'b0;
        step();
        chk("t2_cali", {31'h0, CALI_EN}, 32'h1);
        chk("t2_err", {24'h0, ERR_OUT}, 32'hF0);
        chk("t2_xaln", {16'h0, X_ALN}, {16'h0, xhist[cyc-4]});
        PHE_SIGN = 1'b1;
        step();
        chk("t3_err", {24'h0, ERR_OUT}, 32'h10);
        chk("t3_xaln", {16'h0, X_ALN}, {16'h0, xhist[cyc-4]});
        PHE_VLD = 1'b0;
        step();
        chk("nv_cali", {31'h0, CALI_EN}, 32'h0);
        chk("nv_err", {24'h0, ERR_OUT}, 32'h0);
        chk("nv_xaln", {16'h0, X_ALN}, {16'h0, xhist[cyc-5]});
        PHE_VLD = 1'b1; PHE_SIGN = 1'b0;
        step();
        chk("t4_cali", {31'h0, CALI_EN}, 32'h1);
        chk("t4_err", {24'h0, ERR_OUT}, 32'hF0);
        chk("t4_xaln", {16'h0, X_ALN}, {16'h0, xhist[cyc-4]});

        // Drop EN for one cycle mid-TRACK.
        EN = 1'b0;
        step();
        chk("drop_st", {30'h0, STATE}, 32'd0);
        chk("drop_cali", {31'h0, CALI_EN}, 32'h0);
        chk("drop_err", {24'h0, ERR_OUT}, 32'h0);
        chk("drop_x", {16'h0, X_NOW}, {16'h0, xm});
        chk("drop_c", {31'h0, CARRY}, 32'h0);
        EN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("refill_st", {30'h0, STATE}, 32'd1);
            chk("refill_cali", {31'h0, CALI_EN}, 32'h0);
        end
        step();
        chk("resettle_st", {30'h0, STATE}, 32'd2);

        // Async reset away from the clock edge.
        #2;
        NRST = 1'b0;
        #1;
        xm = 16'h0;
        chk("arst_x", {16'h0, X_NOW}, 32'h0);
        chk("arst_st", {30'h0, STATE}, 32'd0);
        chk("arst_cali", {31'h0, CALI_EN}, 32'h0);
        @(negedge CLK);
        NRST = 1'b1;

        // FCW = 0: phase stays put, no carry.
        FCW_FRAC = 16'h0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("fcw0_x", {16'h0, X_NOW}, 32'h0);
            chk("fcw0_c", {31'h0, CARRY}, 32'h0);
        end
        chk("fcw0_st", {30'h0, STATE}, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
